// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU codes, immediate kinds and the decoded
// control bundle shared by decode_comb and decode_stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [3:0] alu_op;
    logic       is_write;
    logic       alusrc;
    logic       pcsrc;
    logic       regwritesrc;
    logic       mem_acc;
    logic       mem_wr;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers only raise it where legal
  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] r;
    unique case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I/RV64I decoder, instr -> ctrl + imm.
// Ports: instr_i in, ctrl_o/imm_o out. Option: DECODE_ILLEGAL_CHECK_EN.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_z;
  logic        f7_alt;
  logic        sl_ok;
  logic        sr_ok;
  logic        bad;
  imm_t        ityp;
  logic [31:0] imm32;
  ctrl_t       c;

  assign opc    = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign f7_z   = (f7 == 7'h00);
  assign f7_alt = (f7 == 7'h20);

  // RV64 shift immediates carry a 6-bit shamt, so only [31:26] are funct
  assign sl_ok = RV64 ? (instr_i[31:26] == 6'h00) : f7_z;
  assign sr_ok = RV64 ? (instr_i[31:26] == 6'h00 ||
                         instr_i[31:26] == 6'h10)
                      : (f7_z || f7_alt);

  always_comb begin
    c        = '0;
    c.rs1    = instr_i[19:15];
    c.rs2    = instr_i[24:20];
    c.rd     = instr_i[11:7];
    c.funct3 = f3;
    ityp     = IMM_NONE;
    bad      = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI: begin
        ityp = IMM_U; c.alu_op = ALU_PASS_B;
        c.is_write = 1'b1; c.alusrc = 1'b1;
        c.regwritesrc = 1'b1;
      end
      opc == OPC_AUIPC: begin
        ityp = IMM_U; c.is_write = 1'b1;
        c.alusrc = 1'b1; c.regwritesrc = 1'b1;
      end
      opc == OPC_JAL: begin
        ityp = IMM_J; c.is_write = 1'b1;
        c.alusrc = 1'b1; c.pcsrc = 1'b1;
        c.regwritesrc = 1'b1;
      end
      opc == OPC_JALR: begin
        ityp = IMM_I; c.is_write = 1'b1;
        c.alusrc = 1'b1; c.pcsrc = 1'b1;
        c.regwritesrc = 1'b1;
        bad = (f3 != 3'd0);
      end
      opc == OPC_BRANCH: begin
        ityp = IMM_B; c.is_branch = 1'b1;
        bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      opc == OPC_LOAD: begin
        ityp = IMM_I; c.is_write = 1'b1;
        c.alusrc = 1'b1; c.mem_acc = 1'b1;
        bad = (f3 == 3'd7) ||
              (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      opc == OPC_STORE: begin
        ityp = IMM_S; c.alusrc = 1'b1;
        c.mem_acc = 1'b1; c.mem_wr = 1'b1;
        bad = (f3 > 3'd3) || (!RV64 && f3 == 3'd3);
      end
      opc == OPC_OP_IMM: begin
        ityp = IMM_I; c.is_write = 1'b1;
        c.alusrc = 1'b1; c.regwritesrc = 1'b1;
        c.alu_op = alu_of(f3, f3 == 3'd5 && instr_i[30]);
        bad = (f3 == 3'd1 && !sl_ok) ||
              (f3 == 3'd5 && !sr_ok);
      end
      opc == OPC_OP: begin
        c.is_write = 1'b1; c.regwritesrc = 1'b1;
        c.alu_op = alu_of(f3, instr_i[30] &&
                   (f3 == 3'd0 || f3 == 3'd5));
        bad = !(f7_z || (f7_alt &&
                (f3 == 3'd0 || f3 == 3'd5)));
      end
      RV64 && opc == OPC_OP_IMM32: begin
        ityp = IMM_I; c.is_write = 1'b1;
        c.alusrc = 1'b1; c.regwritesrc = 1'b1;
        c.alu_op = alu_of(f3, f3 == 3'd5 && instr_i[30]);
        bad = !((f3 == 3'd0) ||
                (f3 == 3'd1 && f7_z) ||
                (f3 == 3'd5 && (f7_z || f7_alt)));
      end
      RV64 && opc == OPC_OP_32: begin
        c.is_write = 1'b1; c.regwritesrc = 1'b1;
        c.alu_op = alu_of(f3, instr_i[30] &&
                   (f3 == 3'd0 || f3 == 3'd5));
        bad = !((f3 == 3'd1 && f7_z) ||
                ((f3 == 3'd0 || f3 == 3'd5) &&
                 (f7_z || f7_alt)));
      end
      opc == OPC_MISC_MEM: bad = (f3 > 3'd1);
      opc == OPC_SYSTEM:   bad = 1'b0;
      default:             bad = 1'b1;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    c.illegal = bad || (instr_i[1:0] != 2'b11);
    if (c.illegal) begin
      c.is_write  = 1'b0;
      c.mem_acc   = 1'b0;
      c.mem_wr    = 1'b0;
      c.is_branch = 1'b0;
      c.pcsrc     = 1'b0;
    end
`else
    c.illegal = 1'b0;
`endif
    if (c.rd == 5'd0) c.is_write = 1'b0;
  end

`ifndef DECODE_ILLEGAL_CHECK_EN
  logic unused_bad;
  assign unused_bad = bad;
`endif

  always_comb begin
    unique case (ityp)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25],
                      instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31],
                      instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31],
                      instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign ctrl_o = c;
  assign imm_o  = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with 2-entry skid, flush and handshake.
// Ports: in_* fetch side, out_* execute side. Option: DECODE_ILLEGAL_CHECK_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_is_write,
  output logic            out_alusrc,
  output logic            out_pcsrc,
  output logic            out_regwritesrc,
  output logic            out_is_access_memory,
  output logic            out_is_write_memory,
  output logic            out_is_branch,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  typedef struct packed {
    ctrl_t           c;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } ent_t;

  ent_t  dec;
  ent_t  main_q, main_d;
  ent_t  skid_q, skid_d;
  logic  main_v_q, main_v_d;
  logic  skid_v_q, skid_v_d;
  logic  push, pop;

  decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i (in_instr),
    .ctrl_o  (dec.c),
    .imm_o   (dec.imm)
  );
  assign dec.pc = in_pc;

  assign in_ready = !skid_v_q;
  assign push     = in_valid && in_ready;
  assign pop      = main_v_q && out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (pop) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (push) begin
      if (!main_v_q || pop) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end else if (pop) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid            = main_v_q;
  assign out_pc               = main_q.pc;
  assign out_imm              = main_q.imm;
  assign out_rs1              = main_q.c.rs1;
  assign out_rs2              = main_q.c.rs2;
  assign out_rd               = main_q.c.rd;
  assign out_alu_op           = main_q.c.alu_op;
  assign out_is_write         = main_q.c.is_write;
  assign out_alusrc           = main_q.c.alusrc;
  assign out_pcsrc            = main_q.c.pcsrc;
  assign out_regwritesrc      = main_q.c.regwritesrc;
  assign out_is_access_memory = main_q.c.mem_acc;
  assign out_is_write_memory  = main_q.c.mem_wr;
  assign out_is_branch        = main_q.c.is_branch;
  assign out_funct3           = main_q.c.funct3;
  assign out_illegal          = main_q.c.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage at XLEN=64.
// Covers decode fields, skid back-pressure, flush and async reset.
module tb_decode_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic            out_is_write, out_alusrc, out_pcsrc;
  logic            out_regwritesrc, out_is_access_memory;
  logic            out_is_write_memory, out_is_branch;
  logic [2:0]      out_funct3;
  logic            out_illegal;

  int n_chk = 0;
  int n_bad = 0;
  int idx, nout, seen;
  logic acc, pop;
  logic [4:0]  prd;
  logic [63:0] pimm;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_instr             (in_instr),
    .in_pc                (in_pc),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_pc               (out_pc),
    .out_rs1              (out_rs1),
    .out_rs2              (out_rs2),
    .out_rd               (out_rd),
    .out_imm              (out_imm),
    .out_alu_op           (out_alu_op),
    .out_is_write         (out_is_write),
    .out_alusrc           (out_alusrc),
    .out_pcsrc            (out_pcsrc),
    .out_regwritesrc      (out_regwritesrc),
    .out_is_access_memory (out_is_access_memory),
    .out_is_write_memory  (out_is_write_memory),
    .out_is_branch        (out_is_branch),
    .out_funct3           (out_funct3),
    .out_illegal          (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // one beat with out_ready high; leaves us at posedge+1
  task automatic send(input logic [31:0] ins,
                      input logic [63:0] pc);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h123452B7, 64'h100);
    chk("lui_valid", out_valid, 1);
    chk("lui_rd", out_rd, 5);
    chk("lui_imm", out_imm, 64'h12345000);
    chk("lui_alu", out_alu_op, 10);
    chk("lui_wr", out_is_write, 1);
    chk("lui_src", out_alusrc, 1);
    chk("lui_rws", out_regwritesrc, 1);
    chk("lui_pc", out_pc, 64'h100);

    send(32'hFFF00093, 64'h104);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_alu", out_alu_op, 0);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_rd", out_rd, 1);

    send(32'h0020A423, 64'h108);
    chk("sw_imm", out_imm, 8);
    chk("sw_rs1", out_rs1, 1);
    chk("sw_rs2", out_rs2, 2);
    chk("sw_acc", out_is_access_memory, 1);
    chk("sw_wm", out_is_write_memory, 1);
    chk("sw_wr", out_is_write, 0);

    send(32'hFE000EE3, 64'h10C);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_br", out_is_branch, 1);
    chk("beq_f3", out_funct3, 0);
    chk("beq_pcsrc", out_pcsrc, 0);
    chk("beq_wr", out_is_write, 0);

    send(32'h008000EF, 64'h110);
    chk("jal_imm", out_imm, 8);
    chk("jal_pcsrc", out_pcsrc, 1);
    chk("jal_wr", out_is_write, 1);

    send(32'h402081B3, 64'h114);
    chk("sub_alu", out_alu_op, 1);
    chk("sub_src", out_alusrc, 0);
    chk("sub_rd", out_rd, 3);

    send(32'h40325213, 64'h118);
    chk("srai_alu", out_alu_op, 7);
    chk("srai_imm", out_imm, 64'h403);

    send(32'h00208033, 64'h11C);
    chk("add_x0_wr", out_is_write, 0);

    send(32'h00000000, 64'h120);
    chk("zero_wr", out_is_write, 0);
    chk("zero_acc", out_is_access_memory, 0);
    chk("zero_br", out_is_branch, 0);
    chk("zero_pcsrc", out_pcsrc, 0);

    send(32'h022081B3, 64'h124);
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("mul_ill", out_illegal, 1);
    chk("mul_wr", out_is_write, 0);
`else
    chk("mul_ill", out_illegal, 0);
    chk("mul_wr", out_is_write, 1);
`endif

    send(32'h00000000, 64'h128);
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("zero_ill", out_illegal, 1);
`else
    chk("zero_ill", out_illegal, 0);
`endif

    // drain, then back-pressure with 4 back-to-back beats
    @(posedge clk); #1;
    chk("drained", out_valid, 0);
    idx  = 0;
    nout = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid  = (idx < 4);
      in_instr  = addi(idx + 1);
      in_pc     = 64'h200 + 64'(idx * 4);
      out_ready = (cyc >= 3);
      if (cyc <= 1) chk("bp_rdy_open", in_ready, 1);
      if (cyc == 2 || cyc == 3) chk("bp_rdy_low", in_ready, 0);
      if (cyc == 4) chk("bp_rdy_back", in_ready, 1);
      if (cyc == 2) chk("bp_hold_rd", out_rd, 1);
      acc  = in_valid && in_ready;
      pop  = out_valid && out_ready;
      prd  = out_rd;
      pimm = out_imm;
      @(posedge clk); #1;
      if (acc) idx++;
      if (pop) begin
        nout++;
        chk("bp_order_rd", prd, nout);
        chk("bp_order_imm", pimm, nout);
      end
    end
    in_valid = 1'b0;
    chk("bp_in", idx, 4);
    chk("bp_out", nout, 4);

    // flush with 2 held + 1 incoming
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = addi(9);
    @(posedge clk); #1;
    in_instr  = addi(10);
    @(posedge clk); #1;
    chk("fl_full", in_ready, 0);
    in_instr  = addi(11);
    flush     = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("fl_none", seen, 0);

    // flush drops a beat accepted in the same cycle
    in_valid = 1'b1;
    in_instr = addi(12);
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_in_drop", out_valid, 0);
    send(addi(13), 64'h300);
    chk("fl_after_rd", out_rd, 13);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(addi(14), 64'h304);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_imm", out_imm, 0);
    chk("arst_pc", out_pc, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage sitting between fetch and execute. It takes one instruction plus its PC per valid/ready beat and produces register indices, a sign-extended immediate for every base format (I/S/B/U/J), an ALU operation and the datapath control bits. A two-entry skid buffer gives full throughput under back-pressure. A flush input discards in-flight instructions on a redirect.

## Interface
- XLEN, 32, datapath/PC/immediate width; legal values 32 or 64
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded beat valid
- out_ready  in  1  execute accepts beat
- out_pc  out  XLEN  PC of decoded instruction
- out_rs1, out_rs2, out_rd  out  5 each  raw fields [19:15], [24:20], [11:7]
- out_imm  out  XLEN  sign-extended immediate
- out_alu_op  out  4  decode_pkg ALU code
- out_is_write  out  1  write rd; forced 0 when rd==x0
- out_alusrc  out  1  1 = immediate operand B, 0 = rs2
- out_pcsrc  out  1  1 = PC from branch/jump target, 0 = PC+4
- out_regwritesrc  out  1  1 = ALU result, 0 = memory
- out_is_access_memory, out_is_write_memory  out  1 each  load/store
- out_is_branch  out  1  conditional branch; funct3 passes via out_imm-independent field out_funct3 (out, 3)
- out_illegal  out  1  illegal instruction flag

## Operation
- Decodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (FENCE = NOP), SYSTEM (all enables 0). For XLEN=64, OP-IMM-32/OP-32 are also decoded, and shift amounts are 6 bits.
- Immediates: I = {[31:20]}, S = {[31:25],[11:7]}, B = {[31],[7],[30:25],[11:8],0}, J = {[31],[19:12],[20],[30:21],0}, U = {[31:12],12'b0}. All are sign-extended from instr[31] to XLEN.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10 (LUI). AUIPC, JAL, JALR, loads, stores and branches address calculation use ADD.
- out_pcsrc is 1 for JAL and JALR, and 0 for all other instructions. For branches it is 0 and out_is_branch is 1; execute resolves the branch.
- Skid buffer: main and skid registers. in_ready = !skid_valid (registered state only, no combinational path from out_ready).
  - Accept when skid empty: main loads when main is empty or popped this cycle, otherwise skid loads.
  - Pop while skid is full: main <= skid and skid empties; in_ready rises the next cycle.
- flush: both valids clear at the next edge. A beat presented in the same cycle is consumed and dropped; flush has priority over push and pop.
- Reset: all out_* = 0, out_valid = 0, valids cleared; in_ready = 1 once rst_n is high. Asserting rst_n mid-beat drops everything held.

## Timing
- Latency 1 cycle: a beat accepted at edge N appears on out_* after edge N, while out_valid = 1.
- Throughput is 1 beat per cycle with out_ready held high.
- out_* hold stable while out_valid && !out_ready.
- At most 2 beats are held. in_ready is low for exactly the cycles the skid register is full.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined:
  - out_illegal = 1 for: instr[1:0] != 2'b11, unknown opcode, reserved funct3, funct7 not in {0x00, 0x20 where legal}, and 64-bit-only opcodes when XLEN=32.
  - When out_illegal is 1, out_is_write, out_is_access_memory, out_is_write_memory, out_is_branch and out_pcsrc are forced 0.
- Undefined: out_illegal is tied 0, unknown opcodes decode as NOP (all enables 0), and funct7 is checked only on bit 30 for SUB/SRA.

## Structure
- decode_pkg holds the opcode localparams, the ALU code localparams and an immediate-type enum (IMM_I/S/B/U/J/NONE).
- Sub-module decode_comb: a purely combinational instr → fields/control decoder parametrised by XLEN. It is instantiated once on the input side, and decode_stage holds only the skid and handshake state.

## Test plan
- LUI x5,0x12345 (0x123452B7) → 1 cycle later out_valid=1, rd=5, imm=0x12345000, alu_op=10, is_write=1, alusrc=1, regwritesrc=1.
- ADDI x1,x0,-1 (0xFFF00093), XLEN=64 → imm=0xFFFFFFFFFFFFFFFF, alu_op=0, rs1=0.
- SW x2,8(x1) (0x0020A423) → imm=8, rs1=1, rs2=2, is_access_memory=1, is_write_memory=1, is_write=0.
- BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, is_branch=1, funct3=0, pcsrc=0.
- Back-pressure: 4 back-to-back beats with out_ready=0 for 3 cycles → in_ready falls after the 2nd beat, no beat is lost or duplicated, and the output order is preserved.
- flush with 2 beats held plus 1 incoming → out_valid=0 next cycle and none of the 3 emerge. Also 0x00000000 with DECODE_ILLEGAL_CHECK_EN → out_illegal=1 and all enables 0. rst_n pulsed mid-stream → outputs zero immediately.
